// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StChk,
    StDone
  } state_e;

  // Byte address of word idx; wraps mod 2^64.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [31:0]       idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into a little-endian word; word_valid_o marks the byte-3 handshake.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] lanes_q, lanes_d;

  always_comb begin
    lanes_d    = lanes_q;
    byte_idx_d = byte_idx_q;
    if (clear_i) begin
      lanes_d    = '0;
      byte_idx_d = 2'd0;
    end else if (byte_valid_i) begin
      lanes_d[{byte_idx_q, 3'b000} +: 8] = byte_i;
      byte_idx_d                         = byte_idx_q + 2'd1;
    end
  end

  // The word includes the byte arriving this cycle so the consumer can latch it on the edge.
  assign word_o       = lanes_d;
  assign word_valid_o = byte_valid_i && !clear_i && (byte_idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q    <= '0;
      byte_idx_q <= 2'd0;
    end else begin
      lanes_q    <= lanes_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a byte stream, writes little-endian words to IMEM from BASE_ADDR upward.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              in_ready_q, we_q, busy_q, done_q, err_q, err_d;
  logic              hs, pk_clear, pk_word_valid;
  logic [DATA_W-1:0] pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q, xor_d;
`endif

  assign hs = in_valid && in_ready_q;

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pk_clear),
    .byte_valid_i (hs),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    pk_clear   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count == 32'd0 || word_count > 32'(DEPTH)) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            count_d    = word_count;
            word_idx_d = 32'd0;
            pk_clear   = 1'b1;
            state_d    = StRecv;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d      = '0;
`endif
          end
        end
      end
      StRecv: begin
        if (pk_word_valid) begin
          wdata_d = pk_word;
          addr_d  = word_addr(BASE_ADDR, word_idx_q);
          state_d = StWrite;
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q ^ wdata_q;
        state_d = (word_idx_q + 32'd1 == count_q) ? StChk : StRecv;
`else
        state_d = (word_idx_q + 32'd1 == count_q) ? StDone : StRecv;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (pk_word_valid) begin
          state_d = StDone;
          err_d   = (pk_word != xor_q);
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      word_idx_q <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= (state_d == StRecv) || (state_d == StChk);
      we_q       <= (state_d == StWrite);
      busy_q     <= (state_d == StRecv) || (state_d == StWrite) || (state_d == StChk);
      done_q     <= (state_d == StDone);
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction-memory read path.
- Receives a boot/program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into IMEM at sequential byte addresses starting at BASE_ADDR.
- Reports busy/done/err to the boot controller; the core is held in reset until done.

Parameters:
- DEPTH, 1024, IMEM capacity in 32-bit words; upper bound for word_count.
- BASE_ADDR, 64'h0, byte address of the first word written.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load when in IDLE
- word_count  in  32  number of instruction words to load; sampled on start
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream payload
- in_ready  out  1  byte accepted when in_valid && in_ready
- imem_we  out  1  IMEM write strobe, one cycle per word
- imem_addr  out  64  IMEM byte address, word-aligned
- imem_wdata  out  32  IMEM write data
- busy  out  1  high in RECV/WRITE (and CHK when enabled)
- done  out  1  one-cycle pulse at end of load, good or bad
- err  out  1  valid with done; 1 = load failed

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready, imem_we, busy, done, err = 0.
  - imem_addr=BASE_ADDR, imem_wdata=0, byte/word counters=0.
  - A partial word is discarded. IMEM contents are not defined after a mid-load reset.
- States: IDLE, RECV, WRITE, DONE (+CHK with optional feature).
- IDLE:
  - in_ready=0.
  - start with 1<=word_count<=DEPTH: latch the count, clear byte_idx and word_idx, go to RECV.
  - start with word_count==0 or >DEPTH: go to DONE with err=1. No writes occur.
- RECV:
  - in_ready=1.
  - Each handshake stores in_data into word buffer lane byte_idx (byte 0 -> bits 7:0, byte 3 -> bits 31:24).
  - byte_idx increments mod 4.
  - Handshake on byte 3 goes to WRITE.
  - in_valid may drop at any time; no timeout.
- WRITE (one cycle):
  - in_ready=0, imem_we=1, imem_addr=BASE_ADDR+4*word_idx (64-bit, wraps mod 2^64), imem_wdata=buffer.
  - Next cycle: word_idx++.
  - If word_idx+1==count, go to DONE (or CHK when enabled); else go to RECV.
- DONE (one cycle): done=1, err per the rules above, busy=0. Return to IDLE.
- Throughput: 5 cycles minimum per word (4 byte handshakes + 1 write cycle).
- Latency: the last byte handshake is followed by imem_we on the next cycle, then done the cycle after.
- start is ignored outside IDLE. start in the same cycle as the DONE pulse is ignored.
- Outputs are registered. imem_we is low in every cycle outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- Defined:
  - A running XOR of every written word is kept, cleared on start.
  - After the last WRITE the block enters CHK and receives 4 more bytes (same little-endian assembly, in_ready=1).
  - These 4 bytes are not written to IMEM.
  - Go to DONE with err=1 if the received word != the running XOR, else err=0.
- Not defined:
  - No CHK state and no XOR register.
  - err is set only for an illegal word_count.

Decomposition:
- Package imem_loader_pkg:
  - state enum typedef (IDLE, RECV, WRITE, CHK, DONE).
  - WORD_BYTES=4, ADDR_W=64, DATA_W=32.
- Sub-module byte_packer: 4-lane shift/lane register with byte_idx counter, a word_valid pulse, and a clear input. It is reused for both the data words and the checksum word.

Test Plan:
- Basic load: start, word_count=3, stream bytes 13 00 00 00, 93 00 10 00, 33 01 21 00 -> imem_we pulses at addr 0, 4, 8 with data 0x00000013, 0x00100093, 0x00210133, then done=1, err=0. A read-back of words 0..2 returns the same values.
- Backpressure: in_valid toggled 1/0 every cycle, word_count=2 -> identical writes, no duplicate or lost bytes, and imem_we never asserted while in RECV.
- Illegal count: start with word_count=0, and separately with DEPTH+1 -> done=1, err=1 one cycle later, imem_we never asserted.
- Reset mid-load: deassert rst_n after 2 bytes of word 1 (word 0 already written) -> all outputs reset immediately. A new start with word_count=1 writes to BASE_ADDR with fresh bytes only.
- start while busy: pulse start during RECV with word_count=5 -> ignored; the original count completes.
- Checksum (macro defined): 2 words 0x11111111 and 0x22222222, checksum bytes 33 33 33 33 -> err=0. The same load with checksum 0x33333334 -> err=1. In both cases only 2 IMEM writes occur.
